// File: rtl/mem_access_ctrl_if.sv
// Core and loader request/response bundle for the memory access controller.
// The master modport is the requester side (core pipeline / program loader);
// the slave modport is the controller side.
interface mem_access_ctrl_if;
    logic        core_req;
    logic        core_we;
    logic [1:0]  core_len;
    logic        core_sign;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic [31:0] core_rdata;
    logic        core_ready;
    logic        core_err;
    logic        core_stall;
    logic        ld_req;
    logic [31:0] ld_addr;
    logic [31:0] ld_wdata;
    logic        ld_ack;

    modport master (
        output core_req, core_we, core_len, core_sign, core_addr, core_wdata,
        output ld_req, ld_addr, ld_wdata,
        input  core_rdata, core_ready, core_err, core_stall, ld_ack
    );

    modport slave (
        input  core_req, core_we, core_len, core_sign, core_addr, core_wdata,
        input  ld_req, ld_addr, ld_wdata,
        output core_rdata, core_ready, core_err, core_stall, ld_ack
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory access sequencer/arbiter between the CPU core, the program loader,
// the word-wide data RAM and the board MMIO (switches, button, LEDs).
// Sub-word stores are done as read-modify-write; loads are lane-extracted
// and sign/zero extended. The loader has fixed priority over the core.
module mem_access_ctrl #(
    parameter int ADDR_W = 14,
    parameter int LED_W  = 16,
    parameter int SW_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    mem_access_ctrl_if.slave   bus,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic [31:0]        ram_din,
    output logic               ram_we,
    input  logic [31:0]        ram_dout,
    input  logic [SW_W-1:0]    sw_in,
    input  logic               btn_in,
    output logic [LED_W-1:0]   led_out
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_ADDR = 3'd1;
    localparam logic [2:0] ST_RD_DATA = 3'd2;
    localparam logic [2:0] ST_WRITE   = 3'd3;
    localparam logic [2:0] ST_RESP    = 3'd4;

    // Half needs even address, word needs 4-byte alignment; len 3 acts as word.
    function automatic logic is_misaligned(input logic [1:0] len, input logic [1:0] off);
        return ((len == 2'd1) && off[0]) || (len[1] && (off != 2'b00));
    endfunction

    // Shift the addressed lane down and extend it to 32 bits.
    function automatic logic [31:0] load_extract(input logic [31:0] src, input logic [1:0] len,
                                                 input logic sign, input logic [1:0] off);
        logic [31:0] sh_s;
        logic [31:0] res_s;
        case (len)
            2'd0: begin
                sh_s  = src >> {off, 3'b000};
                res_s = {{24{sign & sh_s[7]}}, sh_s[7:0]};
            end
            2'd1: begin
                sh_s  = src >> {off[1], 4'b0000};
                res_s = {{16{sign & sh_s[15]}}, sh_s[15:0]};
            end
            default: begin
                sh_s  = src;
                res_s = src;
            end
        endcase
        return res_s;
    endfunction

    // Replace the addressed byte/half of the old word, little-endian lanes.
    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [15:0] wd,
                                                input logic [1:0] len, input logic [1:0] off);
        logic [31:0] mask_s;
        logic [31:0] data_s;
        case (len)
            2'd0: begin
                mask_s = 32'h0000_00FF << {off, 3'b000};
                data_s = {24'h00_0000, wd[7:0]} << {off, 3'b000};
            end
            2'd1: begin
                mask_s = 32'h0000_FFFF << {off[1], 4'b0000};
                data_s = {16'h0000, wd} << {off[1], 4'b0000};
            end
            default: begin
                mask_s = 32'hFFFF_FFFF;
                data_s = {16'h0000, wd};
            end
        endcase
        return (old & ~mask_s) | (data_s & mask_s);
    endfunction

    // Byte writes hit the low or high LED byte by addr[0]; wider writes load 16 bits.
    function automatic logic [15:0] led_merge(input logic [15:0] old, input logic [15:0] wd,
                                              input logic [1:0] len, input logic a0);
        logic [15:0] res_s;
        case (len)
            2'd0:    res_s = a0 ? {wd[7:0], old[7:0]} : {old[15:8], wd[7:0]};
            default: res_s = wd;
        endcase
        return res_s;
    endfunction

    logic [2:0]        state_r;
    logic [2:0]        state_nx_s;
    logic              owner_ld_r;
    logic              we_r;
    logic [1:0]        len_r;
    logic              sign_r;
    logic [ADDR_W+1:0] addr_r;
    logic [15:0]       wdata_r;
    logic [31:0]       ram_din_r;
    logic              ram_we_r;
    logic [31:0]       core_rdata_r;
    logic              core_ready_r;
    logic              core_err_r;
    logic              ld_ack_r;
    logic [LED_W-1:0]  led_r;
    logic              core_mis_s;
    logic [31:0]       mmio_rd_s;
    logic              unused_ok_s;

    assign core_mis_s = is_misaligned(bus.core_len, bus.core_addr[1:0]);

    // Upper address bits beyond the RAM window and the loader byte offset are don't-care.
    assign unused_ok_s = ^{bus.core_addr[30:ADDR_W+2], bus.ld_addr[30:ADDR_W+2], bus.ld_addr[1:0]};

    assign ram_addr        = addr_r[ADDR_W+1:2];
    assign ram_din         = ram_din_r;
    assign ram_we          = ram_we_r;
    assign led_out         = led_r;
    assign bus.core_rdata  = core_rdata_r;
    assign bus.core_ready  = core_ready_r;
    assign bus.core_err    = core_err_r;
    assign bus.ld_ack      = ld_ack_r;
    assign bus.core_stall  = bus.core_req & ~core_ready_r;

    // MMIO read source selected by addr[5:4], sampled live at the accept edge.
    always_comb begin
        mmio_rd_s = 32'h0000_0000;
        case (bus.core_addr[5:4])
            2'b00:   mmio_rd_s = 32'(sw_in);
            2'b01:   mmio_rd_s = 32'(led_r);
            2'b10:   mmio_rd_s = {31'h0000_0000, btn_in};
            default: mmio_rd_s = 32'h0000_0000;
        endcase
    end

    // Next-state: loader first in IDLE, then path chosen by target and access kind.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.ld_req) begin
                    if (bus.ld_addr[31]) begin
                        state_nx_s = ST_RESP;
                    end else begin
                        state_nx_s = ST_WRITE;
                    end
                end else if (bus.core_req) begin
                    if (core_mis_s || bus.core_addr[31]) begin
                        state_nx_s = ST_RESP;
                    end else if (bus.core_we && bus.core_len[1]) begin
                        state_nx_s = ST_WRITE;
                    end else begin
                        state_nx_s = ST_RD_ADDR;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RD_ADDR: state_nx_s = ST_RD_DATA;
            ST_RD_DATA: begin
                if (we_r) begin
                    state_nx_s = ST_WRITE;
                end else begin
                    state_nx_s = ST_RESP;
                end
            end
            ST_WRITE: state_nx_s = ST_RESP;
            ST_RESP:  state_nx_s = ST_IDLE;
            default:  state_nx_s = ST_IDLE;
        endcase
    end

    // State, request capture, RAM write data and all registered responses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            owner_ld_r   <= 1'b0;
            we_r         <= 1'b0;
            len_r        <= 2'd0;
            sign_r       <= 1'b0;
            addr_r       <= '0;
            wdata_r      <= 16'h0000;
            ram_din_r    <= 32'h0000_0000;
            ram_we_r     <= 1'b0;
            core_rdata_r <= 32'h0000_0000;
            core_ready_r <= 1'b0;
            core_err_r   <= 1'b0;
            ld_ack_r     <= 1'b0;
            led_r        <= '0;
        end else begin
            state_r      <= state_nx_s;
            ram_we_r     <= (state_nx_s == ST_WRITE);
            core_rdata_r <= 32'h0000_0000;
            core_ready_r <= 1'b0;
            core_err_r   <= 1'b0;
            ld_ack_r     <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.ld_req) begin
                        owner_ld_r <= 1'b1;
                        we_r       <= 1'b1;
                        len_r      <= 2'd2;
                        sign_r     <= 1'b0;
                        addr_r     <= bus.ld_addr[ADDR_W+1:0];
                        wdata_r    <= bus.ld_wdata[15:0];
                        ram_din_r  <= bus.ld_wdata;
                        ld_ack_r   <= bus.ld_addr[31];
                    end else if (bus.core_req) begin
                        owner_ld_r <= 1'b0;
                        we_r       <= bus.core_we;
                        len_r      <= bus.core_len;
                        sign_r     <= bus.core_sign;
                        addr_r     <= bus.core_addr[ADDR_W+1:0];
                        wdata_r    <= bus.core_wdata[15:0];
                        ram_din_r  <= bus.core_wdata;
                        if (core_mis_s) begin
                            core_err_r   <= 1'b1;
                            core_ready_r <= 1'b1;
                        end else if (bus.core_addr[31]) begin
                            core_ready_r <= 1'b1;
                            if (bus.core_we) begin
                                if (bus.core_addr[5:4] == 2'b01) begin
                                    led_r <= LED_W'(led_merge(16'(led_r), bus.core_wdata[15:0],
                                                              bus.core_len, bus.core_addr[0]));
                                end
                            end else begin
                                core_rdata_r <= load_extract(mmio_rd_s, bus.core_len,
                                                             bus.core_sign, bus.core_addr[1:0]);
                            end
                        end
                    end
                end
                ST_RD_DATA: begin
                    if (we_r) begin
                        ram_din_r <= store_merge(ram_dout, wdata_r, len_r, addr_r[1:0]);
                    end else begin
                        core_rdata_r <= load_extract(ram_dout, len_r, sign_r, addr_r[1:0]);
                        core_ready_r <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (owner_ld_r) begin
                        ld_ack_r <= 1'b1;
                    end else begin
                        core_ready_r <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
